// File: rtl/frame_serializer_if.sv
// Row-fetch and pixel-stream buses of the frame serializer.
// master = serializer side, slave = row source / pixel sink side.
interface frame_serializer_if #(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int BPP  = 1
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                 oRow_req;
    logic [RW-1:0]        oRow_addr;
    logic                 iRow_valid;
    logic [COLS*BPP-1:0]  iRow_data;
    logic                 oPix_valid;
    logic                 iPix_ready;
    logic [BPP-1:0]       oPixel;
    logic                 oSOF;
    logic                 oEOL;

    modport master (
        output oRow_req, oRow_addr,
        input  iRow_valid, iRow_data,
        output oPix_valid, oPixel, oSOF, oEOL,
        input  iPix_ready
    );

    modport slave (
        input  oRow_req, oRow_addr,
        output iRow_valid, iRow_data,
        input  oPix_valid, oPixel, oSOF, oEOL,
        output iPix_ready
    );
endinterface

// File: rtl/frame_serializer.sv
// Frame serializer: fetches packed rows into a double buffer and streams them
// out one BPP-wide pixel at a time with valid/ready handshaking.
module frame_serializer #(
    parameter int COLS      = 640,
    parameter int ROWS      = 480,
    parameter int BPP       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iSTART,
    input  logic                iABORT,
    frame_serializer_if.master  bus,
    output logic                oBusy,
    output logic                oFinished
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int W  = COLS * BPP;
    localparam logic [CW-1:0] ColLast = CW'(COLS - 1);
    localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StShift} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] addr_q, addr_d;
    logic [W-1:0]  act_q, act_d;
    logic [W-1:0]  pre_q, pre_d;
    logic          act_full_q, act_full_d;
    logic          pre_full_q, pre_full_d;
    logic          req_q, req_d;
    logic          fin_q, fin_d;

    logic          capture;
    logic [RW-1:0] row_inc;
    logic [W-1:0]  act_shifted;

    assign capture = req_q & bus.iRow_valid;
    assign row_inc = row_q + 1'b1;
    assign act_shifted = (MSB_FIRST != 0) ? (act_q << BPP) : (act_q >> BPP);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (iSTART) state_d = StWait;
            StWait:  if (act_full_q || pre_full_q) state_d = StShift;
            StShift: begin
                if (bus.iPix_ready && (col_q == ColLast)) begin
                    if (row_q == RowLast) state_d = StIdle;
                    else if (pre_full_q)  state_d = StShift;
                    else                  state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
        if (iABORT) state_d = StIdle;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            act_q      <= '0;
            pre_q      <= '0;
            act_full_q <= 1'b0;
            pre_full_q <= 1'b0;
            req_q      <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            act_q      <= act_d;
            pre_q      <= pre_d;
            act_full_q <= act_full_d;
            pre_full_q <= pre_full_d;
            req_q      <= req_d;
            fin_q      <= fin_d;
        end
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        act_d      = act_q;
        pre_d      = pre_q;
        act_full_d = act_full_q;
        pre_full_d = pre_full_q;
        req_d      = req_q;
        fin_d      = 1'b0;

        // An empty active buffer always takes the incoming row first.
        if (capture) begin
            req_d = 1'b0;
            if (!act_full_q) begin
                act_d      = bus.iRow_data;
                act_full_d = 1'b1;
            end else begin
                pre_d      = bus.iRow_data;
                pre_full_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (iSTART) begin
                    col_d      = '0;
                    row_d      = '0;
                    addr_d     = '0;
                    req_d      = 1'b1;
                    act_full_d = 1'b0;
                    pre_full_d = 1'b0;
                end
            end
            StWait: begin
                if (act_full_q || pre_full_q) begin
                    // Row landed in prefetch during the row-end cycle: promote it.
                    if (!act_full_q) begin
                        act_d      = pre_q;
                        act_full_d = 1'b1;
                        pre_full_d = 1'b0;
                    end
                    if (row_q != RowLast) begin
                        req_d  = 1'b1;
                        addr_d = row_inc;
                    end
                end
            end
            StShift: begin
                if (bus.iPix_ready) begin
                    act_d = act_shifted;
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            row_d      = '0;
                            fin_d      = 1'b1;
                            act_full_d = 1'b0;
                            pre_full_d = 1'b0;
                        end else begin
                            row_d = row_inc;
                            if (pre_full_q) begin
                                act_d      = pre_q;
                                pre_full_d = 1'b0;
                                if (row_inc != RowLast) begin
                                    req_d  = 1'b1;
                                    addr_d = row_inc + 1'b1;
                                end
                            end else begin
                                act_full_d = 1'b0;
                            end
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (iABORT) begin
            col_d      = '0;
            row_d      = '0;
            addr_d     = '0;
            req_d      = 1'b0;
            act_full_d = 1'b0;
            pre_full_d = 1'b0;
            fin_d      = 1'b0;
        end
    end

    logic           pix_valid;
    logic [BPP-1:0] pixel;
    logic           sof;
    logic           eol;
    logic           busy;

    always_comb begin
        pix_valid = (state_q == StShift);
        pixel     = (MSB_FIRST != 0) ? act_q[W-1 -: BPP] : act_q[BPP-1:0];
        sof       = pix_valid && (row_q == '0) && (col_q == '0);
        eol       = pix_valid && (col_q == ColLast);
        busy      = (state_q != StIdle);
    end

    assign bus.oRow_req   = req_q;
    assign bus.oRow_addr  = addr_q;
    assign bus.oPix_valid = pix_valid;
    assign bus.oPixel     = pixel;
    assign bus.oSOF       = sof;
    assign bus.oEOL       = eol;
    assign oBusy          = busy;
    assign oFinished      = fin_q;
endmodule
